simon_host_bridge: RTL and testbench

- Host-side initiator for the SIMON 128/256 core handshake (newKey/loadKey/doneKey, newData/loadData/doneData/readData).
- Accepts a W-bit word stream from the system and assembles the 256-bit key and the 128-bit blocks.
- Drives them into the core, collects outData and re-serialises the result as a W-bit output stream.
- Sits between the bus/FIFO fabric and the cipher core; the cipher core is instantiated outside this block.

---
 rtl/simon_bridge_pkg.sv | 31 +++
 rtl/simon_word_shifter.sv | 71 +++++++
 rtl/simon_host_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_simon_host_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_bridge_pkg.sv
// simon_bridge_pkg
// Shared definitions for the SIMON 128/256 host bridge:
//   - state_e   : bridge FSM states
//   - KW / BW   : host words per key / per block for the default geometry
//   - cnt_w()   : width of a word counter that must count to n-1
package simon_bridge_pkg;

  typedef enum logic [3:0] {
    IDLE,
    KCOL,
    KSEND,
    KWAIT,
    BCOL,
    BSEND,
    BWAIT,
    RACK,
    DRAIN
  } state_e;

  localparam int N_DEF = 64;
  localparam int M_DEF = 4;
  localparam int W_DEF = 32;
  localparam int KW    = (M_DEF * N_DEF) / W_DEF;
  localparam int BW    = (2 * N_DEF) / W_DEF;

  // A counter for n words needs at least one bit even when n == 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/simon_word_shifter.sv
// simon_word_shifter
// Right-shifting register of NW words of W bits with a word counter.
//   clk_i / rst_ni : clock, asynchronous active-low reset
//   push_i         : shift right, push_data_i enters at the top word
//   pop_i          : shift right, zero enters at the top word
//   load_i         : parallel load of load_data_i, counter cleared
//   data_o         : whole register (word 0 in the low bits)
//   last_o         : counter is on the final word of the frame
// After NW pushes the first word pushed sits at bits [W-1:0], so word k
// ends up at [k*W +: W]. After a parallel load, pops present word k at
// the bottom on the k-th step.
module simon_word_shifter
  import simon_bridge_pkg::*;
#(
  parameter int W  = 32,
  parameter int NW = 4,
  parameter int CW = cnt_w(NW)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [W-1:0]    push_data_i,
  input  logic            pop_i,
  input  logic            load_i,
  input  logic [W*NW-1:0] load_data_i,
  output logic [W*NW-1:0] data_o,
  output logic            last_o
);

  localparam int TOT = W * NW;

  logic [TOT-1:0] data_q, data_d, shifted;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   fill;

  assign fill = push_i ? push_data_i : '0;

  generate
    if (NW == 1) begin : g_single
      assign shifted = fill;
    end else begin : g_multi
      assign shifted = {fill, data_q[TOT-1:W]};
    end
  endgenerate

  assign last_o = (cnt_q == CW'(NW - 1));
  assign data_o = data_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
    end else if (push_i || pop_i) begin
      data_d = shifted;
      cnt_d  = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/simon_host_bridge.sv
// simon_host_bridge
// Host-side initiator for the SIMON 128/256 core handshake. Collects a
// W-bit host stream into a key (M*N bits) or a block (2*N bits), hands
// them to the core, and re-serialises the core result LSW first.
//   host in   : in_valid, in_ready, in_data, in_is_key, in_dec
//   host out  : out_valid, out_ready, out_data
//   status    : key_loaded, err (sticky until reset)
//   core side : newKey, newData, enc_dec, readData, KEY, blockIN,
//               loadKey, loadData, doneKey, doneData, outData
module simon_host_bridge
  import simon_bridge_pkg::*;
#(
  parameter int N    = 64,
  parameter int M    = 4,
  parameter int W    = 32,
  parameter int TOUT = 255,
  parameter int TB   = 8
) (
  input  logic           clk,
  input  logic           nR,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_is_key,
  input  logic           in_dec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           key_loaded,
  output logic           err,
  output logic           newKey,
  output logic           newData,
  output logic           enc_dec,
  output logic           readData,
  output logic [M*N-1:0] KEY,
  output logic [2*N-1:0] blockIN,
  input  logic           loadKey,
  input  logic           loadData,
  input  logic           doneKey,
  input  logic           doneData,
  input  logic [2*N-1:0] outData
);

  localparam int KEY_WORDS = (M * N) / W;
  localparam int BLK_WORDS = (2 * N) / W;

  state_e        state_q;
  logic          run_q;
  logic          key_loaded_q;
  logic          err_q;
  logic          new_key_q;
  logic          new_data_q;
  logic          read_data_q;
  logic          enc_dec_q;
  logic [TB-1:0] wd_q;

  logic accept, key_push, blk_push, res_load, res_pop;
  logic key_last, blk_last, res_last;
  logic wd_expired;
  logic [2*N-1:0] res_data;
  logic unused_res_bits;

  // run_q keeps in_ready low while reset is held and for the first edge.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:       in_ready = run_q & ~(in_valid & ~in_is_key & ~key_loaded_q);
      KCOL, BCOL: in_ready = 1'b1;
      default:    in_ready = 1'b0;
    endcase
  end

  assign accept   = in_valid & in_ready;
  // Words with the wrong frame flag are consumed but never pushed.
  assign key_push = accept &  in_is_key & (state_q == IDLE || state_q == KCOL);
  assign blk_push = accept & ~in_is_key & (state_q == IDLE || state_q == BCOL);
  assign res_load = (state_q == BWAIT) & doneData;
  assign res_pop  = (state_q == DRAIN) & out_ready;

  assign wd_expired = (wd_q == TB'(TOUT - 1));

  simon_word_shifter #(.W(W), .NW(KEY_WORDS)) u_key_sh (
    .clk_i       (clk),
    .rst_ni      (nR),
    .push_i      (key_push),
    .push_data_i (in_data),
    .pop_i       (1'b0),
    .load_i      (1'b0),
    .load_data_i ('0),
    .data_o      (KEY),
    .last_o      (key_last)
  );

  simon_word_shifter #(.W(W), .NW(BLK_WORDS)) u_blk_sh (
    .clk_i       (clk),
    .rst_ni      (nR),
    .push_i      (blk_push),
    .push_data_i (in_data),
    .pop_i       (1'b0),
    .load_i      (1'b0),
    .load_data_i ('0),
    .data_o      (blockIN),
    .last_o      (blk_last)
  );

  simon_word_shifter #(.W(W), .NW(BLK_WORDS)) u_res_sh (
    .clk_i       (clk),
    .rst_ni      (nR),
    .push_i      (1'b0),
    .push_data_i ('0),
    .pop_i       (res_pop),
    .load_i      (res_load),
    .load_data_i (outData),
    .data_o      (res_data),
    .last_o      (res_last)
  );

  // Only the bottom word is ever presented; upper words reach it by popping.
  assign out_data        = res_data[W-1:0];
  assign unused_res_bits = ^res_data[2*N-1:W];

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
      new_key_q    <= 1'b0;
      new_data_q   <= 1'b0;
      read_data_q  <= 1'b0;
      enc_dec_q    <= 1'b0;
      wd_q         <= '0;
    end else begin
      run_q       <= 1'b1;
      new_key_q   <= 1'b0;
      new_data_q  <= 1'b0;
      read_data_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_is_key) begin
              state_q <= key_last ? KSEND : KCOL;
            end else begin
              enc_dec_q <= ~in_dec;
              if (!blk_last) begin
                state_q <= BCOL;
              end else if (loadData) begin
                new_data_q <= 1'b1;
                wd_q       <= '0;
                state_q    <= BWAIT;
              end else begin
                state_q <= BSEND;
              end
            end
          end
        end
        KCOL: begin
          if (accept) begin
            if (!in_is_key) err_q <= 1'b1;
            else if (key_last) state_q <= KSEND;
          end
        end
        KSEND: begin
          if (loadKey) begin
            new_key_q <= 1'b1;
            wd_q      <= '0;
            state_q   <= KWAIT;
          end
        end
        KWAIT: begin
          if (doneKey) begin
            key_loaded_q <= 1'b1;
            state_q      <= IDLE;
          end else if (wd_expired) begin
            err_q        <= 1'b1;
            key_loaded_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            wd_q <= wd_q + TB'(1);
          end
        end
        BCOL: begin
          // The last block word launches newData straight away when the
          // core is already ready, giving one cycle from last word.
          if (accept) begin
            if (in_is_key) begin
              err_q <= 1'b1;
            end else if (blk_last) begin
              if (loadData) begin
                new_data_q <= 1'b1;
                wd_q       <= '0;
                state_q    <= BWAIT;
              end else begin
                state_q <= BSEND;
              end
            end
          end
        end
        BSEND: begin
          if (loadData) begin
            new_data_q <= 1'b1;
            wd_q       <= '0;
            state_q    <= BWAIT;
          end
        end
        BWAIT: begin
          if (doneData) begin
            read_data_q <= 1'b1;
            state_q     <= RACK;
          end else if (wd_expired) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + TB'(1);
          end
        end
        RACK:    state_q <= DRAIN;
        DRAIN:   if (out_ready && res_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = (state_q == DRAIN);
  assign key_loaded = key_loaded_q;
  assign err        = err_q;
  assign newKey     = new_key_q;
  assign newData    = new_data_q;
  assign readData   = read_data_q;
  assign enc_dec    = enc_dec_q;

endmodule

// File: tb/tb_simon_host_bridge.sv
// tb_simon_host_bridge
// Directed bench for simon_host_bridge. The core side is driven by hand;
// result words are queued when outData is driven and compared LSW first
// as they leave the bridge.
module tb_simon_host_bridge;
  import simon_bridge_pkg::*;

  localparam int N    = 64;
  localparam int M    = 4;
  localparam int W    = 32;
  localparam int TOUT = 255;
  localparam int TBW  = 8;

  logic           clk = 1'b0;
  logic           nR = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           in_is_key = 1'b0;
  logic           in_dec = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           key_loaded, err;
  logic           newKey, newData, enc_dec, readData;
  logic [M*N-1:0] KEY;
  logic [2*N-1:0] blockIN;
  logic           loadKey = 1'b0;
  logic           loadData = 1'b0;
  logic           doneKey = 1'b0;
  logic           doneData = 1'b0;
  logic [2*N-1:0] outData = '0;

  always #5 clk = ~clk;

  simon_host_bridge #(.N(N), .M(M), .W(W), .TOUT(TOUT), .TB(TBW)) dut (
    .clk(clk), .nR(nR),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_is_key(in_is_key), .in_dec(in_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_loaded(key_loaded), .err(err),
    .newKey(newKey), .newData(newData), .enc_dec(enc_dec), .readData(readData),
    .KEY(KEY), .blockIN(blockIN),
    .loadKey(loadKey), .loadData(loadData), .doneKey(doneKey), .doneData(doneData),
    .outData(outData)
  );

  int passes = 0;
  int total = 0;
  int nk_cnt = 0;
  int nd_cnt = 0;
  int rd_cnt = 0;

  logic [W-1:0]   sb[$];
  logic [M*N-1:0] exp_key = '0;
  logic [2*N-1:0] exp_blk = '0;
  logic           exp_enc = 1'b0;
  logic           rdy_s = 1'b0;
  logic           hold_v = 1'b0;
  logic [W-1:0]   hold_d = '0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic checkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Looks at what the bridge presents just before the coming rising edge.
  task automatic monitor();
    logic [W-1:0] e;
    if (hold_v) checkw("out_hold", 256'(out_data), 256'(hold_d));
    hold_v = out_valid & ~out_ready;
    hold_d = out_data;
    if (out_valid && out_ready) begin
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      checkw("out_word", 256'(out_data), 256'(e));
    end
    if (newKey) begin
      nk_cnt++;
      checkw("key_at_newkey", KEY, exp_key);
    end
    if (newData) begin
      nd_cnt++;
      checkw("block_at_newdata", 256'(blockIN), 256'(exp_blk));
      check1("enc_dec_at_newdata", enc_dec, exp_enc);
    end
    if (readData) rd_cnt++;
  endtask

  task automatic cyc();
    #1;
    rdy_s = in_ready;
    monitor();
    @(negedge clk);
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return newKey;
      1:       return newData;
      default: return out_valid;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int limit);
    int n = 0;
    while (!probe(which) && n < limit) begin
      cyc();
      n++;
    end
    check1(tag, probe(which), 1'b1);
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic k, input logic dec);
    int n = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_is_key = k;
    in_dec    = dec;
    rdy_s     = 1'b0;
    while (!rdy_s && n < 100) begin
      cyc();
      n++;
    end
    check1("word_accepted", rdy_s, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [2*N-1:0] b, input logic dec);
    exp_blk = b;
    exp_enc = ~dec;
    for (int j = 0; j < BW; j++) send_word(b[j*W +: W], 1'b0, dec);
  endtask

  task automatic core_done(input logic [2*N-1:0] r);
    outData = r;
    for (int j = 0; j < BW; j++) sb.push_back(r[j*W +: W]);
    doneData = 1'b1;
    cyc();
    doneData = 1'b0;
  endtask

  task automatic drain(input logic toggle);
    int n = 0;
    while (out_valid && n < 40) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      cyc();
      n++;
    end
    out_ready = 1'b0;
    check1("drain_done", out_valid, 1'b0);
    checki("sb_empty", sb.size(), 0);
  endtask

  function automatic logic [2*N-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0]   kw;
    logic [W-1:0]   kw2[KW];
    logic [2*N-1:0] blk0, r;
    int             nd0;

    // Reset values
    repeat (3) @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_key_loaded", key_loaded, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_enc_dec", enc_dec, 1'b0);
    checkw("rst_key", KEY, '0);
    checkw("rst_block", 256'(blockIN), '0);
    nR = 1'b1;
    cyc();
    check1("in_ready_after_rst", in_ready, 1'b1);

    // Block word before any key: stalled, no error
    blk0      = rnd_blk();
    in_valid  = 1'b1;
    in_is_key = 1'b0;
    in_data   = blk0[W-1:0];
    repeat (3) cyc();
    check1("stall_no_key", rdy_s, 1'b0);
    check1("stall_no_err", err, 1'b0);
    in_valid = 1'b0;

    // Key frame 0x03020100 .. 0x1f1e1d1c
    loadKey  = 1'b1;
    loadData = 1'b1;
    for (int k = 0; k < KW; k++) begin
      kw = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      exp_key[k*W +: W] = kw;
    end
    for (int k = 0; k < KW; k++) send_word(exp_key[k*W +: W], 1'b1, 1'b0);
    wait_for("newkey_seen", 0, 20);
    doneKey = 1'b1;
    cyc();
    doneKey = 1'b0;
    check1("key_loaded_set", key_loaded, 1'b1);

    // Stalled block now accepted; encrypt, one-cycle newData latency
    send_block(blk0, 1'b0);
    check1("newdata_latency", newData, 1'b1);
    repeat (3) cyc();
    r = rnd_blk();
    core_done(r);
    check1("rack_readdata", readData, 1'b1);
    check1("rack_no_out", out_valid, 1'b0);
    cyc();
    check1("readdata_one_cycle", readData, 1'b0);
    check1("drain_valid", out_valid, 1'b1);
    drain(1'b0);

    // Backpressure: loadData low 10 cycles, out_ready toggling; decrypt
    loadData = 1'b0;
    send_block(rnd_blk(), 1'b1);
    nd0 = nd_cnt;
    repeat (10) cyc();
    checki("newdata_waits_load", nd_cnt, nd0);
    loadData = 1'b1;
    wait_for("newdata_after_load", 1, 5);
    repeat (2) cyc();
    core_done(rnd_blk());
    wait_for("drain_bp_start", 2, 5);
    drain(1'b1);

    // Watchdog: doneData on the expiry cycle wins
    send_block(rnd_blk(), 1'b0);
    repeat (TOUT - 1) cyc();
    core_done(rnd_blk());
    check1("wd_done_wins_err", err, 1'b0);
    check1("wd_done_wins_rack", readData, 1'b1);
    cyc();
    drain(1'b0);

    // Watchdog: no doneData, err exactly TOUT cycles after BWAIT entry
    send_block(rnd_blk(), 1'b0);
    repeat (TOUT - 1) cyc();
    check1("wd_pre_err", err, 1'b0);
    check1("wd_pre_busy", in_ready, 1'b0);
    cyc();
    check1("wd_err", err, 1'b1);
    check1("wd_back_idle", in_ready, 1'b1);

    // Reset, then key frame with a mismatched word 3
    nR = 1'b0;
    repeat (2) cyc();
    check1("rst2_err", err, 1'b0);
    check1("rst2_key_loaded", key_loaded, 1'b0);
    nR = 1'b1;
    cyc();
    for (int k = 0; k < KW; k++) begin
      kw2[k] = $urandom;
      exp_key[k*W +: W] = kw2[k];
    end
    for (int k = 0; k < 3; k++) send_word(kw2[k], 1'b1, 1'b0);
    check1("mismatch_pre_err", err, 1'b0);
    send_word(32'hdeadbeef, 1'b0, 1'b0);
    check1("mismatch_err", err, 1'b1);
    for (int k = 3; k < KW; k++) send_word(kw2[k], 1'b1, 1'b0);
    wait_for("newkey2_seen", 0, 20);
    doneKey = 1'b1;
    cyc();
    doneKey = 1'b0;
    check1("key2_loaded", key_loaded, 1'b1);

    // Reset in the middle of DRAIN after two words
    send_block(rnd_blk(), 1'b1);
    cyc();
    core_done(rnd_blk());
    cyc();
    out_ready = 1'b1;
    repeat (2) cyc();
    out_ready = 1'b0;
    nR = 1'b0;
    #1;
    check1("mid_rst_out_valid", out_valid, 1'b0);
    checkw("mid_rst_out_data", 256'(out_data), '0);
    check1("mid_rst_key_loaded", key_loaded, 1'b0);
    check1("mid_rst_err", err, 1'b0);
    check1("mid_rst_in_ready", in_ready, 1'b0);
    checkw("mid_rst_key", KEY, '0);
    checkw("mid_rst_block", 256'(blockIN), '0);
    sb.delete();
    hold_v = 1'b0;
    @(negedge clk);
    nR = 1'b1;
    cyc();
    check1("post_rst_out_valid", out_valid, 1'b0);
    check1("post_rst_key_loaded", key_loaded, 1'b0);
    check1("post_rst_in_ready", in_ready, 1'b1);

    checki("newkey_pulses", nk_cnt, 2);
    checki("newdata_pulses", nd_cnt, 5);
    checki("readdata_pulses", rd_cnt, 4);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
